// File: rtl/button_conditioner.sv
// button_conditioner: two independent button channels (sync, debounce, press/release pulses).
// Auto-repeat FSM is built only when BUTTON_AUTOREPEAT_EN is defined; otherwise btn_repeat is 0.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 160000,
    parameter int REPEAT_DELAY    = 8000000,
    parameter int REPEAT_PERIOD   = 1600000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] btn_n,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release,
    output logic [1:0] btn_repeat
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
`endif
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic          r_s1, r_s2, r_level, r_press, r_release;
        logic [DW-1:0] r_cnt;
        logic          w_flip;
        assign w_flip = (r_s2 != r_level) && (r_cnt == DW'(DEBOUNCE_CYCLES));
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_s1      <= ~btn_n[i];
                r_s2      <= r_s1;
                r_cnt     <= (r_s2 == r_level || w_flip) ? '0 : r_cnt + 1'b1;
                r_level   <= r_level ^ w_flip;
                r_press   <= w_flip & ~r_level;
                r_release <= w_flip & r_level;
            end
        end
        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
`ifdef BUTTON_AUTOREPEAT_EN
        typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
        state_t        r_state;
        logic [HW-1:0] r_hold;
        logic          r_repeat;
        // hold counter is preloaded to 1 so it equals the cycles elapsed since the last pulse
        always_ff @(posedge CLK) begin
            if (RST || (w_flip && r_level)) begin
                r_state  <= IDLE;
                r_hold   <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_repeat <= 1'b0;
                if (r_state == IDLE) begin
                    r_hold <= HW'(1);
                    if (w_flip) r_state <= DELAY;
                end else if (r_hold == HW'(r_state == DELAY ? REPEAT_DELAY : REPEAT_PERIOD)) begin
                    r_state  <= REPEAT;
                    r_hold   <= HW'(1);
                    r_repeat <= 1'b1;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
        assign btn_repeat[i] = r_repeat;
`else
        assign btn_repeat[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random holds/glitches/resets checked every cycle
// against a sample-history model of the debounce and repeat-timing rules.
module tb_button_conditioner;
    localparam int DEB = 4, RD = 20, RP = 5, N = 8192;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [1:0] x_level, x_press, x_release, x_repeat;
    int  checks = 0, passed = 0, e = 0;
    bit  hist [2][N];
    bit  lvl [2];
    int  last_tog [2];
`ifdef BUTTON_AUTOREPEAT_EN
    bit  held [2];
    int  pe [2];
`endif

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .CLK(CLK), .RST(RST), .btn_n(btn_n), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s at edge %0d: got %b expected %b", tag, e, got, exp);
    endtask

    // A level change is accepted once the synchronized input (raw delayed two edges) has
    // disagreed with the level for DEB+1 consecutive edges since the last change or reset.
    task automatic model();
        for (int i = 0; i < 2; i++) begin
            bit tog;
            x_press[i]   = 1'b0;
            x_release[i] = 1'b0;
            x_repeat[i]  = 1'b0;
            if (RST) begin
                hist[i][e] = 1'b0;
                if (e > 0) hist[i][e-1] = 1'b0;
                lvl[i]      = 1'b0;
                last_tog[i] = e;
`ifdef BUTTON_AUTOREPEAT_EN
                held[i] = 1'b0;
`endif
            end else begin
                hist[i][e] = ~btn_n[i];
                tog = (e - DEB) > last_tog[i];
                if (tog)
                    for (int k = e - 2 - DEB; k <= e - 2; k++)
                        if (hist[i][k] == lvl[i]) tog = 1'b0;
                if (tog) begin
                    x_press[i]   = !lvl[i];
                    x_release[i] = lvl[i];
                    lvl[i]       = !lvl[i];
                    last_tog[i]  = e;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                if (x_press[i]) begin
                    held[i] = 1'b1;
                    pe[i]   = e;
                end else if (x_release[i]) begin
                    held[i] = 1'b0;
                end else if (held[i]) begin
                    int d;
                    d = e - pe[i];
                    x_repeat[i] = (d == RD) || (d > RD && (d - RD) % RP == 0);
                end
`endif
            end
            x_level[i] = lvl[i];
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] b, input int n);
        repeat (n) begin
            @(negedge CLK);
            RST   = rst;
            btn_n = b;
            @(posedge CLK);
            model();
            #1;
            check("btn_level", btn_level, x_level);
            check("btn_press", btn_press, x_press);
            check("btn_release", btn_release, x_release);
            check("btn_repeat", btn_repeat, x_repeat);
            e++;
        end
    endtask

    initial begin
        step(1'b1, 2'b00, 3);
        step(1'b0, 2'b00, 10);
        step(1'b0, 2'b11, 10);
        step(1'b0, 2'b10, 3);
        step(1'b0, 2'b11, 10);
        step(1'b0, 2'b10, 12);
        step(1'b0, 2'b11, 10);
        step(1'b0, 2'b01, 66);
        step(1'b0, 2'b11, 15);
        step(1'b0, 2'b00, 18);
        step(1'b0, 2'b01, 30);
        step(1'b0, 2'b11, 15);
        step(1'b0, 2'b00, 10);
        step(1'b1, 2'b00, 2);
        step(1'b0, 2'b00, 10);
        step(1'b0, 2'b11, 12);
        step(1'b0, 2'b11, 1);
        step(1'b1, 2'b11, 1);
        step(1'b0, 2'b10, 40);
        step(1'b0, 2'b11, 12);
        for (int r = 0; r < 60; r++) begin
            logic [1:0] b;
            b = 2'($urandom);
            if ($urandom_range(0, 15) == 0) step(1'b1, b, $urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 1) step(1'b0, b, $urandom_range(1, 5));
            else step(1'b0, b, $urandom_range(6, 45));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
